// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline types for the memory arbiter: source/state enums and bus widths.
package pipeline_types;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int NUM_SRC = 4;

  // Encoding order is also the default priority and the round-robin rotation order.
  typedef enum logic [1:0] {
    SRC_DC_WR = 2'd0,
    SRC_DC_RD = 2'd1,
    SRC_UC    = 2'd2,
    SRC_IC_RD = 2'd3
  } arb_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic arb_src_e src_of(input logic [NUM_SRC-1:0] gnt);
    arb_src_e s;
    if (gnt[0])      s = SRC_DC_WR;
    else if (gnt[1]) s = SRC_DC_RD;
    else if (gnt[2]) s = SRC_UC;
    else             s = SRC_IC_RD;
    return s;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the memory arbiter.
// slave = arbiter view, master = requesters plus memory model view.
interface mem_arbiter_if;
  import pipeline_types::*;

  logic              ic_rd_req;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic [LINE_W-1:0] ic_rd_data;
  logic              ic_rd_done;

  logic              dc_rd_req;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic [LINE_W-1:0] dc_rd_data;
  logic              dc_rd_done;

  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [LINE_W-1:0] dc_wr_data;
  logic              dc_wr_done;

  logic              uc_req;
  logic              uc_we;
  logic [ADDR_W-1:0] uc_addr;
  logic [31:0]       uc_wdata;
  logic [3:0]        uc_strb;
  logic [31:0]       uc_rdata;
  logic              uc_done;

  logic              mem_req;
  logic              mem_we;
  logic              mem_uncache;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [3:0]        mem_strb;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
    input  dc_wr_req, dc_wr_addr, dc_wr_data,
    input  uc_req, uc_we, uc_addr, uc_wdata, uc_strb,
    input  mem_rdata, mem_valid,
    output ic_rd_data, ic_rd_done, dc_rd_data, dc_rd_done, dc_wr_done,
    output uc_rdata, uc_done,
    output mem_req, mem_we, mem_uncache, mem_addr, mem_wdata, mem_strb
  );

  modport master (
    output ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
    output dc_wr_req, dc_wr_addr, dc_wr_data,
    output uc_req, uc_we, uc_addr, uc_wdata, uc_strb,
    output mem_rdata, mem_valid,
    input  ic_rd_data, ic_rd_done, dc_rd_data, dc_rd_done, dc_wr_done,
    input  uc_rdata, uc_done,
    input  mem_req, mem_we, mem_uncache, mem_addr, mem_wdata, mem_strb
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: the source just after ptr has highest priority,
// ptr itself has lowest. Output is one-hot (all zero when nothing requests).
module mem_arb_pick
  import pipeline_types::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  arb_src_e           ptr,
  output logic [NUM_SRC-1:0] gnt
);

  logic [1:0]         base;
  logic [NUM_SRC-1:0] rot;
  logic [NUM_SRC-1:0] rot_gnt;

  assign base = 2'(ptr) + 2'd1;

  // Rotate so bit 0 is the highest-priority source, take the lowest set bit, rotate back.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
    assign rot[gi] = req[base + 2'(gi)];
  end

  assign rot_gnt = rot & (~rot + 4'd1);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unrot
    assign gnt[gi] = rot_gnt[2'(gi) - base];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Four-source line/word memory arbiter, one transaction in flight at a time.
// Optional MEM_ARB_ROUND_ROBIN_EN: rotate priority after each grant instead of fixed order.
module mem_arbiter
  import pipeline_types::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e         state_reg;
  arb_src_e           src_reg;
  arb_src_e           ptr;
  arb_src_e           win;
  logic [NUM_SRC-1:0] req_vec;
  logic [NUM_SRC-1:0] gnt;

  logic              mem_req_reg;
  logic              mem_we_reg;
  logic              mem_uncache_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [LINE_W-1:0] mem_wdata_reg;
  logic [3:0]        mem_strb_reg;
  logic [LINE_W-1:0] ic_rd_data_reg;
  logic [LINE_W-1:0] dc_rd_data_reg;
  logic [31:0]       uc_rdata_reg;
  logic              ic_rd_done_reg;
  logic              dc_rd_done_reg;
  logic              dc_wr_done_reg;
  logic              uc_done_reg;

  assign req_vec = {bus.ic_rd_req, bus.uc_req, bus.dc_rd_req, bus.dc_wr_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_src_e ptr_reg;
  assign ptr = ptr_reg;
`else
  assign ptr = SRC_IC_RD;
`endif

  mem_arb_pick u_pick (
    .req (req_vec),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign win = src_of(gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      src_reg         <= SRC_IC_RD;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_uncache_reg <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_strb_reg    <= '0;
      ic_rd_data_reg  <= '0;
      dc_rd_data_reg  <= '0;
      uc_rdata_reg    <= '0;
      ic_rd_done_reg  <= 1'b0;
      dc_rd_done_reg  <= 1'b0;
      dc_wr_done_reg  <= 1'b0;
      uc_done_reg     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_reg         <= SRC_IC_RD;
`endif
    end else begin
      // Pulses default low; each state raises only what it owns.
      mem_req_reg    <= 1'b0;
      ic_rd_done_reg <= 1'b0;
      dc_rd_done_reg <= 1'b0;
      dc_wr_done_reg <= 1'b0;
      uc_done_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            src_reg     <= win;
            mem_req_reg <= 1'b1;
            state_reg   <= ISSUE;
            case (win)
              SRC_DC_WR: begin
                mem_addr_reg    <= bus.dc_wr_addr;
                mem_we_reg      <= 1'b1;
                mem_uncache_reg <= 1'b0;
                mem_wdata_reg   <= bus.dc_wr_data;
                mem_strb_reg    <= 4'b0000;
              end
              SRC_DC_RD: begin
                mem_addr_reg    <= bus.dc_rd_addr;
                mem_we_reg      <= 1'b0;
                mem_uncache_reg <= 1'b0;
                mem_strb_reg    <= 4'b0000;
              end
              SRC_UC: begin
                mem_addr_reg    <= bus.uc_addr;
                mem_we_reg      <= bus.uc_we;
                mem_uncache_reg <= 1'b1;
                mem_strb_reg    <= bus.uc_strb;
                if (bus.uc_we) begin
                  mem_wdata_reg <= {{(LINE_W-32){1'b0}}, bus.uc_wdata};
                end
              end
              default: begin
                mem_addr_reg    <= bus.ic_rd_addr;
                mem_we_reg      <= 1'b0;
                mem_uncache_reg <= 1'b0;
                mem_strb_reg    <= 4'b0000;
              end
            endcase
          end
        end
        ISSUE: state_reg <= WAIT;
        WAIT: begin
          if (bus.mem_valid) begin
            state_reg <= RESP;
            case (src_reg)
              SRC_DC_WR: dc_wr_done_reg <= 1'b1;
              SRC_DC_RD: begin
                dc_rd_data_reg <= bus.mem_rdata;
                dc_rd_done_reg <= 1'b1;
              end
              SRC_UC: begin
                if (!mem_we_reg) begin
                  uc_rdata_reg <= bus.mem_rdata[31:0];
                end
                uc_done_reg <= 1'b1;
              end
              default: begin
                ic_rd_data_reg <= bus.mem_rdata;
                ic_rd_done_reg <= 1'b1;
              end
            endcase
          end
        end
        RESP: begin
          state_reg <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_reg   <= src_reg;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_uncache = mem_uncache_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.mem_strb    = mem_strb_reg;
  assign bus.ic_rd_data  = ic_rd_data_reg;
  assign bus.dc_rd_data  = dc_rd_data_reg;
  assign bus.uc_rdata    = uc_rdata_reg;
  assign bus.ic_rd_done  = ic_rd_done_reg;
  assign bus.dc_rd_done  = dc_rd_done_reg;
  assign bus.dc_wr_done  = dc_wr_done_reg;
  assign bus.uc_done     = uc_done_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-timeline model.
// Honors MEM_ARB_ROUND_ROBIN_EN to match the DUT build.
module tb_mem_arbiter;
  import pipeline_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Requester state; index = arb_src_e encoding.
  logic        pend   [4];
  logic        req_on [4];
  logic        allow  [4];
  logic [31:0] p_addr [4];
  logic [255:0] p_line [4];
  logic        uc_we_m;
  logic [31:0] uc_wdata_m;
  logic [3:0]  uc_strb_m;

  // Transaction timeline for the one transaction in flight.
  arb_src_e order[$];
  int win, issue_cyc, resp_cyc, done_cyc, free_cyc;
  logic [255:0] exp_line, last_ic, last_dc;
  int delay_fix, drop_pct, new_pct, spur_pct;
  int done_log[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_inputs();
    bus.dc_wr_req  = req_on[0];
    bus.dc_wr_addr = p_addr[0];
    bus.dc_wr_data = p_line[0];
    bus.dc_rd_req  = req_on[1];
    bus.dc_rd_addr = p_addr[1];
    bus.uc_req     = req_on[2];
    bus.uc_addr    = p_addr[2];
    bus.uc_we      = uc_we_m;
    bus.uc_wdata   = uc_wdata_m;
    bus.uc_strb    = uc_strb_m;
    bus.ic_rd_req  = req_on[3];
    bus.ic_rd_addr = p_addr[3];
  endtask

  task automatic new_req(input int s);
    pend[s]   = 1'b1;
    req_on[s] = 1'b1;
    p_addr[s] = $urandom & 32'hFFFF_FFE0;
    if (s == 0) p_line[0] = rand_line();
    if (s == 2) begin
      p_addr[2]  = $urandom & 32'hFFFF_FFFC;
      uc_we_m    = 1'($urandom_range(1));
      uc_wdata_m = $urandom;
      uc_strb_m  = 4'($urandom_range(15));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_done", {bus.ic_rd_done, bus.uc_done, bus.dc_rd_done, bus.dc_wr_done}, 4'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_uncache", bus.mem_uncache, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 256'h0);
    check("rst_mem_strb", bus.mem_strb, 4'h0);
    check("rst_ic_rd_data", bus.ic_rd_data, 256'h0);
    check("rst_dc_rd_data", bus.dc_rd_data, 256'h0);
    check("rst_uc_rdata", bus.uc_rdata, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 4; s++) begin
      pend[s] = 1'b0; req_on[s] = 1'b0; allow[s] = 1'b1;
      p_addr[s] = '0; p_line[s] = '0;
    end
    uc_we_m = 1'b0; uc_wdata_m = '0; uc_strb_m = '0;
    order = {SRC_DC_WR, SRC_DC_RD, SRC_UC, SRC_IC_RD};
    win = -1; issue_cyc = -1; resp_cyc = -1; done_cyc = -1;
    last_ic = '0; last_dc = '0; exp_line = '0;
    done_log.delete();
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    set_inputs();
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    free_cyc = cyc;
    check_reset_outputs();
  endtask

  // One clock: check outputs of this cycle, then drive inputs for it.
  task automatic step();
    logic [3:0] dn, dn_exp;
    logic       in_wait, exp_we;
    int         just;
    just   = -1;
    dn     = {bus.ic_rd_done, bus.uc_done, bus.dc_rd_done, bus.dc_wr_done};
    dn_exp = (win >= 0 && cyc == done_cyc) ? (4'b0001 << win) : 4'b0000;
    check("mem_req", bus.mem_req, (win >= 0 && cyc == issue_cyc));
    check("done_vec", dn, dn_exp);
    if (win >= 0 && cyc == issue_cyc) begin
      exp_we = (win == 0) ? 1'b1 : ((win == 2) ? uc_we_m : 1'b0);
      check("mem_addr", bus.mem_addr, p_addr[win]);
      check("mem_we", bus.mem_we, exp_we);
      check("mem_uncache", bus.mem_uncache, (win == 2));
      if (win == 0) check("mem_wdata", bus.mem_wdata, p_line[0]);
      if (win == 2) begin
        check("mem_strb", bus.mem_strb, uc_strb_m);
        if (uc_we_m) check("mem_wdata_lo", bus.mem_wdata[31:0], uc_wdata_m);
      end
    end
    if (win >= 0 && cyc == done_cyc) begin
      if (win == 3) last_ic = exp_line;
      if (win == 1) last_dc = exp_line;
      if (win == 2 && !uc_we_m) check("uc_rdata", bus.uc_rdata, exp_line[31:0]);
      $display("txn src=%0d addr=%h done_cyc=%0d", win, p_addr[win], cyc);
      done_log.push_back(win);
      pend[win]   = 1'b0;
      req_on[win] = 1'b0;
      just        = win;
      win         = -1;
    end
    check("ic_rd_data", bus.ic_rd_data, last_ic);
    check("dc_rd_data", bus.dc_rd_data, last_dc);

    for (int s = 0; s < 4; s++)
      if (!pend[s] && s != just && allow[s] && int'($urandom_range(99)) < new_pct) new_req(s);
    if (win >= 0 && cyc > issue_cyc && req_on[win] && int'($urandom_range(99)) < drop_pct)
      req_on[win] = 1'b0;

    in_wait = (win >= 0) && (cyc > issue_cyc) && (cyc < resp_cyc);
    bus.mem_rdata = rand_line();
    if (win >= 0 && cyc == resp_cyc) begin
      bus.mem_valid = 1'b1;
      exp_line = bus.mem_rdata;
    end else begin
      bus.mem_valid = !in_wait && (int'($urandom_range(99)) < spur_pct);
    end

    if (win < 0 && cyc >= free_cyc) begin
      for (int i = 0; i < order.size(); i++)
        if (win < 0 && req_on[int'(order[i])]) win = int'(order[i]);
      if (win >= 0) begin
        issue_cyc = cyc + 1;
        resp_cyc  = issue_cyc + ((delay_fix > 0) ? delay_fix : int'($urandom_range(4, 1)));
        done_cyc  = resp_cyc + 1;
        free_cyc  = resp_cyc + 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        while (int'(order[$]) != win) order.push_back(order.pop_front());
`endif
      end
    end
    set_inputs();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((win >= 0 || pend[0] || pend[1] || pend[2] || pend[3]) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", (n < budget), 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    delay_fix = -1; drop_pct = 0; new_pct = 0; spur_pct = 0;
    do_reset();

    // Single icache refill, memory answers 3 cycles after mem_req.
    delay_fix = 3;
    new_req(3);
    p_addr[3] = 32'h1C00_0000;
    drain(40);
    check("ic_single_count", done_log.size(), 1);

    // All four at once after reset: priority order.
    do_reset();
    delay_fix = -1;
    for (int s = 0; s < 4; s++) new_req(s);
    drain(100);
    check("all4_count", done_log.size(), 4);
    for (int i = 0; i < 4 && i < done_log.size(); i++) check("all4_order", done_log[i], i);

    // Uncached write.
    new_req(2);
    p_addr[2] = 32'hBFAF_8000; uc_we_m = 1'b1; uc_wdata_m = 32'h1234_5678; uc_strb_m = 4'b0011;
    drain(40);

    // dc_rd drops its request after ISSUE, then mem_valid pulses while idle.
    drop_pct = 100;
    new_req(1);
    drain(40);
    drop_pct = 0;
    spur_pct = 100;
    repeat (5) step();
    spur_pct = 0;

    // Reset in the middle of WAIT, then a late mem_valid.
    new_req(3);
    n = 0;
    while (!(win >= 0 && cyc == issue_cyc + 1) && n < 20) begin
      step();
      n++;
    end
    check("reach_wait", (n < 20), 1'b1);
    do_reset();
    spur_pct = 100;
    repeat (4) step();
    spur_pct = 0;
    check_reset_outputs();

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // dc_wr and ic_rd held continuously alternate.
    do_reset();
    allow[1] = 1'b0; allow[2] = 1'b0;
    new_pct = 100;
    n = 0;
    while (done_log.size() < 4 && n < 200) begin
      step();
      n++;
    end
    new_pct = 0;
    drain(60);
    check("rr_count", (done_log.size() >= 4), 1'b1);
    for (int i = 0; i < 4 && i < done_log.size(); i++) check("rr_alt", done_log[i], (i % 2 == 0) ? 0 : 3);
    for (int s = 0; s < 4; s++) allow[s] = 1'b1;
`endif

    // Random mix of traffic, drops and stray mem_valid.
    do_reset();
    new_pct = 25; drop_pct = 20; spur_pct = 20;
    repeat (1500) step();
    new_pct = 0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 ADDR_W, 32, byte-address width of all ports.
REQ-002 LINE_W, 256, cache-line data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ic_rd_req  input  1  icache line-refill request, held until ic_rd_done.
REQ-006 ic_rd_addr  input  ADDR_W  icache refill line address.
REQ-007 ic_rd_data  output  LINE_W  refill line, valid when ic_rd_done=1.
REQ-008 ic_rd_done  output  1  one-cycle completion pulse.
REQ-009 dc_rd_req  input  1  dcache line-refill request, held until dc_rd_done.
REQ-010 dc_rd_addr  input  ADDR_W  dcache refill line address.
REQ-011 dc_rd_data  output  LINE_W  refill line, valid when dc_rd_done=1.
REQ-012 dc_rd_done  output  1  one-cycle completion pulse.
REQ-013 dc_wr_req  input  1  dcache line-writeback request, held until dc_wr_done.
REQ-014 dc_wr_addr  input  ADDR_W  writeback line address.
REQ-015 dc_wr_data  input  LINE_W  writeback line.
REQ-016 dc_wr_done  output  1  one-cycle completion pulse.
REQ-017 uc_req  input  1  uncached word access, held until uc_done.
REQ-018 uc_we  input  1  1=write, 0=read.
REQ-019 uc_addr / uc_wdata / uc_strb  input  ADDR_W / 32 / 4  uncached address, write data, byte strobes.
REQ-020 uc_rdata / uc_done  output  32 / 1  uncached read data, valid with the one-cycle done pulse.
REQ-021 mem_req / mem_we / mem_uncache  output  1 each  memory request pulse, write flag, uncached flag.
REQ-022 mem_addr / mem_wdata / mem_strb  output  ADDR_W / LINE_W / 4  memory address, write data (uncached word in bits [31:0]), uncached strobes.
REQ-023 mem_rdata / mem_valid  input  LINE_W / 1  memory response data; one-cycle valid pulse for reads and writes.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction is in flight at any time.
REQ-025 IDLE: when any *_req=1, latch the winner's source, address, we, data and strobes; go to ISSUE next cycle; with no request, stay in IDLE.
REQ-026 ISSUE: drive mem_req=1 for exactly this one cycle with the latched fields; go to WAIT.
REQ-027 WAIT: ignore mem_valid=0; on mem_valid=1, register mem_rdata and go to RESP.
REQ-028 RESP: pulse the winner's *_done for one cycle with its data output driven from the registered response; go to IDLE.
REQ-029 Latency: request seen in IDLE at cycle N gives mem_req at N+1; mem_valid at cycle M (M>=N+2) gives done at M+1; the next arbitration occurs at M+2.
REQ-030 Fixed priority on simultaneous requests: dc_wr > dc_rd > uc > ic_rd.
REQ-031 Requests are sampled only in IDLE; deassertion of a request while its transaction is in flight is ignored, and the transaction still completes with a done pulse.
REQ-032 mem_valid outside WAIT is ignored.
REQ-033 *_data, uc_rdata and mem_* data fields hold their last value between transactions; mem_req is 0 outside ISSUE.
REQ-034 A requester reasserting its request in the cycle after its done pulse is arbitrated normally in IDLE.

Reset
REQ-035 rst=1 at any state, including mid-WAIT, forces IDLE on the next edge; no done pulse is generated for the aborted transaction.
REQ-036 Reset values: every *_done=0, mem_req=0, mem_we=0, mem_uncache=0, all address, data and strobe outputs=0, round-robin pointer=ic_rd (lowest).

Configuration
REQ-037 With MEM_ARB_ROUND_ROBIN_EN defined, the most recently granted source becomes lowest priority after each RESP, with the order rotating dc_wr -> dc_rd -> uc -> ic_rd; the post-reset order equals REQ-030.
REQ-038 Without MEM_ARB_ROUND_ROBIN_EN, fixed priority per REQ-030 applies and no pointer register exists.

Structure
REQ-039 The shared pipeline_types package holds arb_src_e (SRC_DC_WR, SRC_DC_RD, SRC_UC, SRC_IC_RD) and arb_state_e.
REQ-040 The combinational winner selection is the single sub-module mem_arb_pick (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-041 Single ic_rd_req at 0x1C000000, mem_valid 3 cycles after mem_req -> mem_req one cycle with addr 0x1C000000 and we=0, ic_rd_done exactly one cycle, ic_rd_data equals mem_rdata.
REQ-042 All four requests asserted together in fixed mode -> done order dc_wr, dc_rd, uc, ic_rd, with exactly one mem_req per transaction.
REQ-043 Uncached write: uc_we=1, uc_addr 0xBFAF8000, uc_wdata 0x12345678, uc_strb 4'b0011 -> mem_uncache=1, mem_we=1, mem_wdata[31:0]=0x12345678, mem_strb=4'b0011, then uc_done.
REQ-044 rst asserted during WAIT, then mem_valid arrives -> no done pulse, FSM in IDLE, all outputs at reset values.
REQ-045 With MEM_ARB_ROUND_ROBIN_EN, dc_wr and ic_rd held continuously -> grants alternate dc_wr, ic_rd, dc_wr, ic_rd.
REQ-046 dc_rd_req dropped one cycle after ISSUE -> dc_rd_done still pulses after mem_valid; mem_valid injected in IDLE -> ignored.
